// File: rtl/hex_scan_pkg.sv
// Shared types for the hex scanner: serializer FSM states and the 7-segment decode.
package hex_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/shift_out_engine.sv
// W-bit MSB-first 74HC595 serializer: word taken on i_start in IDLE, st_cp rises 2*W*SCLK_DIV cycles later.
// No backpressure: i_start is ignored unless o_idle; o_done pulses once the latch pulse ends.
module shift_out_engine
    import hex_scan_pkg::*;
#(
    parameter int W        = 16,
    parameter int SCLK_DIV = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [W-1:0] i_word,
    output logic         o_idle,
    output logic         o_done,
    output logic         o_sh_cp,
    output logic         o_st_cp,
    output logic         o_ds
);

    localparam int DIVW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BITW = (W > 1) ? $clog2(W) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCLK_DIV - 1);

    state_t          r_state;
    logic [W-1:0]    r_word;
    logic [BITW-1:0] r_bit;
    logic [DIVW-1:0] r_div;
    logic            r_sh_cp;
    logic            r_st_cp;
    logic            r_ds;
    logic            r_done;

    logic            w_div_end;
    logic [BITW-1:0] w_bit_nxt;

    assign w_div_end = (r_div == DIV_LAST);
    assign w_bit_nxt = r_bit - 1'b1;

    // ds only changes on entry to SHIFT_LO, so it is stable across every sh_cp rise.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_sh_cp <= 1'b0;
            r_st_cp <= 1'b0;
            r_ds    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_word  <= i_word;
                        r_bit   <= BITW'(W - 1);
                        r_ds    <= i_word[W-1];
                        r_sh_cp <= 1'b0;
                        r_div   <= '0;
                        r_state <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sh_cp <= 1'b1;
                        r_state <= ST_SHIFT_HI;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sh_cp <= 1'b0;
                        if (r_bit == '0) begin
                            r_st_cp <= 1'b1;
                            r_state <= ST_LATCH;
                        end else begin
                            r_bit   <= w_bit_nxt;
                            r_ds    <= r_word[w_bit_nxt];
                            r_state <= ST_SHIFT_LO;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_st_cp <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_idle  = (r_state == ST_IDLE);
    assign o_done  = r_done;
    assign o_sh_cp = r_sh_cp;
    assign o_st_cp = r_st_cp;
    assign o_ds    = r_ds;

endmodule

// File: rtl/hex_scan_serial.sv
// Multiplexed 7-seg scanner driving a 595 chain; one digit per scan tick, st_cp 2*W*SCLK_DIV+1 cycles after tick.
// Loads are staged and applied only at frame start (load_ack); optional HEX_SCAN_LEADING_ZERO_BLANK_EN blanks leading zeros.
module hex_scan_serial
    import hex_scan_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int SCLK_DIV       = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [4*DIGITS-1:0]   i_disp_data,
    input  logic [DIGITS-1:0]     i_dp_mask,
    input  logic [DIGITS-1:0]     i_digit_en,
    input  logic                  i_load,
    output logic                  o_load_ack,
    output logic                  o_sh_cp,
    output logic                  o_st_cp,
    output logic                  o_ds,
    output logic                  o_frame_done
);

    localparam int W        = 8 + DIGITS;
    localparam int SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CNTW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (!((W * 2 + 2) * SCLK_DIV < SCAN_DIV)) begin : g_scan_too_fast
        $error("hex_scan_serial: one digit transfer does not fit in a scan period");
    end

    logic [CNTW-1:0]       r_scan_cnt;
    logic [4*DIGITS-1:0]   r_stg_data, r_sh_data;
    logic [DIGITS-1:0]     r_stg_dp, r_sh_dp;
    logic [DIGITS-1:0]     r_stg_en, r_sh_en;
    logic                  r_load_pend;
    logic                  r_tick_pend;
    logic [IDXW-1:0]       r_idx;
    logic                  r_load_ack;
    logic                  r_frame_done;

    logic                  w_tick, w_busy, w_start, w_xfer;
    logic                  w_eng_idle, w_eng_done;
    logic [4*DIGITS-1:0]   w_src_data;
    logic [DIGITS-1:0]     w_src_dp, w_src_en;
    logic [3:0]            w_nib;
    logic                  w_show, w_dp, w_hnz;
    logic [6:0]            w_seg;
    logic [DIGITS-1:0]     w_sel;
    logic [W-1:0]          w_word;

    assign w_tick  = (r_scan_cnt == CNTW'(SCAN_DIV - 1));
    // The done cycle still holds the old index, so the engine counts as busy until it advances.
    assign w_busy  = !w_eng_idle || w_eng_done;
    assign w_start = !w_busy && (w_tick || r_tick_pend);
    assign w_xfer  = r_load_pend && !w_busy && (r_idx == '0);

    // A transfer coinciding with a start feeds the new data straight into digit 0.
    assign w_src_data = w_xfer ? r_stg_data : r_sh_data;
    assign w_src_dp   = w_xfer ? r_stg_dp   : r_sh_dp;
    assign w_src_en   = w_xfer ? r_stg_en   : r_sh_en;

    always_comb begin
        w_nib = w_src_data[{r_idx, 2'b00} +: 4];
        w_hnz = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j > int'(r_idx) && w_src_en[j] && (w_src_data[4*j +: 4] != 4'h0))
                w_hnz = 1'b1;
        end
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        w_show = w_src_en[r_idx] && !((r_idx != '0) && (w_nib == 4'h0) && !w_hnz);
`else
        w_show = w_src_en[r_idx];
`endif
        w_dp  = w_src_en[r_idx] && w_src_dp[r_idx];
        w_seg = w_show ? seg_decode(w_nib) : SEG_OFF;
        w_sel = '0;
        if (w_show)
            w_sel[r_idx] = 1'b1;
        w_word = {((SEG_ACTIVE_LOW != 0) ? ~w_dp  : w_dp),
                  ((SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg),
                  ((SEL_ACTIVE_LOW != 0) ? ~w_sel : w_sel)};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scan_cnt   <= '0;
            r_stg_data   <= '0;
            r_stg_dp     <= '0;
            r_stg_en     <= '0;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_en      <= '0;
            r_load_pend  <= 1'b0;
            r_tick_pend  <= 1'b0;
            r_idx        <= '0;
            r_load_ack   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;

            if (i_load) begin
                r_stg_data  <= i_disp_data;
                r_stg_dp    <= i_dp_mask;
                r_stg_en    <= i_digit_en;
                r_load_pend <= 1'b1;
            end else if (w_xfer) begin
                r_load_pend <= 1'b0;
            end

            if (w_xfer) begin
                r_sh_data <= r_stg_data;
                r_sh_dp   <= r_stg_dp;
                r_sh_en   <= r_stg_en;
            end
            r_load_ack <= w_xfer;

            // One tick of slack; anything beyond that is dropped.
            r_tick_pend <= w_tick ? (w_busy || r_tick_pend) : (r_tick_pend && !w_start);

            r_frame_done <= 1'b0;
            if (w_eng_done) begin
                r_idx        <= (r_idx == IDXW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
                r_frame_done <= (r_idx == IDXW'(DIGITS - 1));
            end
        end
    end

    shift_out_engine #(
        .W        (W),
        .SCLK_DIV (SCLK_DIV)
    ) u_shift (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_start),
        .i_word  (w_word),
        .o_idle  (w_eng_idle),
        .o_done  (w_eng_done),
        .o_sh_cp (o_sh_cp),
        .o_st_cp (o_st_cp),
        .o_ds    (o_ds)
    );

    assign o_load_ack   = r_load_ack;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_scan_serial.sv
// Bench for hex_scan_serial: decodes the 595 pin stream into latched words and scores them against a display model.
module tb_hex_scan_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] disp_data = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  digit_en = '0;
    logic        load = 1'b0;
    logic        load_ack, sh_cp, st_cp, ds, frame_done;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_scan_serial #(
        .DIGITS(8), .CLK_FREQ_HZ(1_000_000), .SCAN_HZ(10_000), .SCLK_DIV(2),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_disp_data(disp_data), .i_dp_mask(dp_mask),
        .i_digit_en(digit_en), .i_load(load), .o_load_ack(load_ack), .o_sh_cp(sh_cp),
        .o_st_cp(st_cp), .o_ds(ds), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Pin-level view of the 595 chain: shift on sh_cp rise, latch on st_cp rise.
    int          cyc = 0;
    logic [15:0] sr = '0;
    logic        prev_sh = 1'b0, prev_st = 1'b0;
    logic [15:0] wq[$];
    int          wcyc[$];
    int          ack_cnt = 0, fd_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            sr = '0; prev_sh = 1'b0; prev_st = 1'b0;
        end else begin
            if (sh_cp && !prev_sh) sr = {sr[14:0], ds};
            if (st_cp && !prev_st) begin wq.push_back(sr); wcyc.push_back(cyc); end
            if (load_ack)   ack_cnt++;
            if (frame_done) fd_cnt++;
            prev_sh = sh_cp; prev_st = st_cp;
        end
    end

    // What a display with active-low segments and selects should receive for digit k.
    function automatic logic [15:0] model_word(input logic [31:0] d, input logic [7:0] dp,
                                               input logic [7:0] en, input int k);
        logic [3:0]  nib;
        logic [6:0]  seg;
        logic [7:0]  sel;
        logic        dpb;
        bit          blank;
        logic [31:0] masked;
        nib   = 4'((d >> (4 * k)) & 32'hF);
        blank = 1'b0;
        masked = '0;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        for (int j = 0; j < 8; j++)
            if (j == k || (j > k && en[j])) masked = masked | (d & (32'hF << (4 * j)));
        blank = (k > 0) && ((masked >> (4 * k)) == 0);
`endif
        seg = (en[k] && !blank) ? SEG_TBL[nib] : 7'h00;
        sel = (en[k] && !blank) ? 8'(1 << k) : 8'h00;
        dpb = en[k] & dp[k];
        return {~dpb, ~seg, ~sel};
    endfunction

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        @(negedge clk);
        disp_data = d; dp_mask = dp; digit_en = en; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && wq.size() < n; i++) @(negedge clk);
        ok = (wq.size() >= n);
    endtask

    task automatic wait_frame(input int budget, output bit ok);
        int f0 = fd_cnt;
        for (int i = 0; i < budget && fd_cnt == f0; i++) @(negedge clk);
        ok = (fd_cnt != f0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (sh_cp !== 1'b0)      begin n_fail++; $display("FAIL reset_sh_cp: got %b want 0", sh_cp); end
        n_cmp++; if (st_cp !== 1'b0)      begin n_fail++; $display("FAIL reset_st_cp: got %b want 0", st_cp); end
        n_cmp++; if (ds !== 1'b0)         begin n_fail++; $display("FAIL reset_ds: got %b want 0", ds); end
        n_cmp++; if (load_ack !== 1'b0)   begin n_fail++; $display("FAIL reset_load_ack: got %b want 0", load_ack); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    endtask

    task automatic test_first_frame;
        bit ok;
        @(negedge clk);
        rst = 1'b0;
        wq.delete(); wcyc.delete(); ack_cnt = 0; fd_cnt = 0;
        disp_data = 32'h01234567; dp_mask = 8'h00; digit_en = 8'hFF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_words(8, 1200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL first_frame_timeout: got %0d words want 8", wq.size()); end
        if (ok) begin
            // Tick fires when the scan counter reaches 99; latch follows 65 cycles later.
            n_cmp++; if (wcyc[0] !== 164) begin n_fail++; $display("FAIL first_latency: got cycle %0d want 164", wcyc[0]); end
            n_cmp++; if (wq[0] !== 16'hF8FE) begin n_fail++; $display("FAIL first_digit0: got %h want f8fe", wq[0]); end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (wq[k] !== model_word(32'h01234567, 8'h00, 8'hFF, k)) begin
                    n_fail++; $display("FAIL first_digit%0d: got %h want %h", k, wq[k], model_word(32'h01234567, 8'h00, 8'hFF, k));
                end
            end
        end
        repeat (10) @(negedge clk);
        n_cmp++; if (ack_cnt !== 1) begin n_fail++; $display("FAIL first_ack_count: got %0d want 1", ack_cnt); end
        n_cmp++; if (fd_cnt !== 1)  begin n_fail++; $display("FAIL first_frame_done: got %0d want 1", fd_cnt); end
    endtask

    task automatic run_frame(input string name, input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        bit ok;
        wait_frame(1200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s_frame_timeout: got none want frame_done", name); end
        wq.delete();
        do_load(d, dp, en);
        wait_words(8, 1200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s_words_timeout: got %0d want 8", name, wq.size()); end
        for (int k = 0; k < 8 && ok; k++) begin
            n_cmp++;
            if (wq[k] !== model_word(d, dp, en, k)) begin
                n_fail++; $display("FAIL %s_digit%0d: got %h want %h (data %h dp %h en %h)", name, k, wq[k], model_word(d, dp, en, k), d, dp, en);
            end
        end
    endtask

    task automatic test_enable_dp;
        run_frame("en_dp", 32'h89ABCDEF, 8'h01, 8'h7F);
        if (wq.size() >= 8) begin
            n_cmp++; if (wq[7] !== 16'hFFFF) begin n_fail++; $display("FAIL en_dp_digit7_off: got %h want ffff", wq[7]); end
            n_cmp++; if (wq[0] !== 16'h0EFE) begin n_fail++; $display("FAIL en_dp_digit0_F: got %h want 0efe", wq[0]); end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++)
            run_frame("random", $urandom, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_midframe_load;
        bit ok;
        int a1;
        run_frame("mid_ones", 32'h11111111, 8'h00, 8'hFF);
        wq.delete();
        wait_words(3, 1200, ok);
        a1 = ack_cnt;
        do_load(32'h22222222, 8'h00, 8'hFF);
        wait_words(8, 1200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_timeout: got %0d words want 8", wq.size()); end
        for (int k = 3; k < 8 && ok; k++) begin
            n_cmp++;
            if (wq[k] !== model_word(32'h11111111, 8'h00, 8'hFF, k)) begin
                n_fail++; $display("FAIL mid_old_digit%0d: got %h want %h", k, wq[k], model_word(32'h11111111, 8'h00, 8'hFF, k));
            end
        end
        n_cmp++; if (ack_cnt !== a1) begin n_fail++; $display("FAIL mid_no_early_ack: got %0d want %0d", ack_cnt, a1); end
        wait_words(16, 1200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_next_timeout: got %0d words want 16", wq.size()); end
        for (int k = 0; k < 8 && ok; k++) begin
            n_cmp++;
            if (wq[8+k] !== model_word(32'h22222222, 8'h00, 8'hFF, k)) begin
                n_fail++; $display("FAIL mid_new_digit%0d: got %h want %h", k, wq[8+k], model_word(32'h22222222, 8'h00, 8'hFF, k));
            end
        end
        n_cmp++; if (ack_cnt !== a1 + 1) begin n_fail++; $display("FAIL mid_ack_once: got %0d want %0d", ack_cnt, a1 + 1); end
    endtask

    task automatic test_reset_mid_shift;
        bit ok;
        int i;
        wait_frame(1200, ok);
        for (i = 0; i < 200 && !sh_cp; i++) @(negedge clk);
        n_cmp++; if (!sh_cp) begin n_fail++; $display("FAIL rst_mid_no_shift: got sh_cp 0 want activity"); end
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sh_cp !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sh_cp: got %b want 0", sh_cp); end
        n_cmp++; if (st_cp !== 1'b0) begin n_fail++; $display("FAIL rst_mid_st_cp: got %b want 0", st_cp); end
        n_cmp++; if (ds !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_ds: got %b want 0", ds); end
        repeat (3) @(negedge clk);
        wq.delete(); wcyc.delete();
        rst = 1'b0;
        disp_data = 32'h0000ABCD; dp_mask = 8'h02; digit_en = 8'hFF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_words(1, 400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_mid_restart_timeout: got no latch want one"); end
        if (ok) begin
            n_cmp++; if (wcyc[0] !== 164) begin n_fail++; $display("FAIL rst_mid_latency: got cycle %0d want 164", wcyc[0]); end
            n_cmp++;
            if (wq[0] !== model_word(32'h0000ABCD, 8'h02, 8'hFF, 0)) begin
                n_fail++; $display("FAIL rst_mid_digit0: got %h want %h", wq[0], model_word(32'h0000ABCD, 8'h02, 8'hFF, 0));
            end
        end
    endtask

    task automatic test_zero_data;
        run_frame("zeros_340", 32'h00000340, 8'h00, 8'hFF);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        for (int k = 3; k < 8 && wq.size() >= 8; k++) begin
            n_cmp++; if (wq[k] !== 16'hFFFF) begin n_fail++; $display("FAIL lzb_blank_digit%0d: got %h want ffff", k, wq[k]); end
        end
        run_frame("zeros_all", 32'h00000000, 8'h00, 8'hFF);
        if (wq.size() >= 8) begin
            n_cmp++; if (wq[0] !== 16'hC0FE) begin n_fail++; $display("FAIL lzb_digit0_zero: got %h want c0fe", wq[0]); end
            n_cmp++; if (wq[1] !== 16'hFFFF) begin n_fail++; $display("FAIL lzb_digit1_blank: got %h want ffff", wq[1]); end
        end
`else
        if (wq.size() >= 8) begin
            n_cmp++; if (wq[3] !== 16'hC0F7) begin n_fail++; $display("FAIL zero_digit3_shown: got %h want c0f7", wq[3]); end
        end
`endif
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_enable_dp;
        test_random;
        test_midframe_load;
        test_reset_mid_shift;
        test_zero_data;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_scan_serial.md
Name: hex_scan_serial

Overview:
- Parametrised N-digit multiplexed 7-segment scanner with an integrated 74HC595 chain serializer, in one block.
- Captures a packed hex display word through a load handshake and double-buffers it, so updates never tear mid-frame.
- Scans one digit per scan tick and shifts {dp, seg, sel} out MSB-first on sh_cp/ds, then pulses st_cp.
- Sits at the display-facing top of the design, directly driving the board's 595 pins.

Parameters:
- DIGITS, 8: number of digits; sel width.
- CLK_FREQ_HZ, 50_000_000: clk frequency.
- SCAN_HZ, 1000: digit-advance rate.
- SCLK_DIV, 2: sh_cp/st_cp half-period, in clk cycles, >=1.
- SEG_ACTIVE_LOW, 1: seg and dp inverted when 1.
- SEL_ACTIVE_LOW, 1: sel inverted when 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- disp_data  in  4*DIGITS  nibble k displays on digit k.
- dp_mask  in  DIGITS  decimal point on for digit k.
- digit_en  in  DIGITS  digit k enabled; disabled digits are blanked.
- load  in  1  single-cycle request to capture disp_data/dp_mask/digit_en.
- load_ack  out  1  one-cycle pulse when the shadow register takes the pending load.
- sh_cp  out  1  595 shift clock.
- st_cp  out  1  595 storage/latch clock.
- ds  out  1  595 serial data.
- frame_done  out  1  one-cycle pulse when digit DIGITS-1's latch completes.

Behaviour:
- Reset values:
  - sh_cp=0, st_cp=0, ds=0, load_ack=0, frame_done=0.
  - Digit index=0, shadow register all zero, pending flags cleared, FSM=IDLE.
- Scan timer:
  - Counts to CLK_FREQ_HZ/SCAN_HZ-1, then emits a tick and wraps to 0.
  - Elaboration check: (W*2+2)*SCLK_DIV < CLK_FREQ_HZ/SCAN_HZ, where W=8+DIGITS.
- Load handshake:
  - A load pulse sets load_pend and captures the inputs into a staging register.
  - A later load before transfer overwrites the staging register; last wins.
  - Transfer staging->shadow happens only in IDLE, and only when the digit index is 0 at the start of a frame.
  - load_ack pulses on the transfer cycle and load_pend clears.
- Frame word, W bits, MSB first: {dp, seg[6:0], sel[DIGITS-1:0]}.
  - seg = {g,f,e,d,c,b,a}, full hex 0-F decode.
  - Active-high codes: 0=0x3F, 1=0x06, 7=0x07, 8=0x7F, F=0x71.
  - Inversion is applied per SEG_ACTIVE_LOW.
  - sel has only bit k active. If digit_en[k]=0, seg and dp are forced off and sel is all inactive.
- FSM:
  - IDLE: on tick (or pending tick), load the word and set bit counter=W-1 -> SHIFT_LO.
  - SHIFT_LO: ds=word[bit], sh_cp=0 for SCLK_DIV cycles -> SHIFT_HI.
  - SHIFT_HI: sh_cp=1 for SCLK_DIV cycles. If bit==0 -> LATCH, else decrement -> SHIFT_LO.
  - LATCH: sh_cp=0, st_cp=1 for SCLK_DIV cycles, then st_cp=0.
    - Digit index increments, wrapping DIGITS-1 -> 0.
    - frame_done pulses when index wraps to 0.
    - Return to IDLE.
- Tick while not in IDLE: held in a 1-deep tick_pend and serviced on return to IDLE. Further ticks are dropped.
- Latency: first st_cp rise occurs 2*W*SCLK_DIV+1 cycles after the tick.
- ds holds stable across each sh_cp rising edge.
- Reset mid-shift: all outputs return to reset values immediately; the partial word is discarded.

Optional Feature:
- Macro: HEX_SCAN_LEADING_ZERO_BLANK_EN.
- When defined:
  - Digit k (k>=1) is blanked (seg off, sel inactive, dp still honoured) when its nibble and all higher enabled nibbles are 0.
  - Digit 0 is never blanked.
- When undefined: all enabled digits are displayed, including zeros.

Decomposition:
- Package hex_scan_pkg holds:
  - the FSM state enum;
  - the 16-entry active-high segment table constant (or a decode function);
  - the SEG_OFF constant.
- One natural sub-module, shift_out_engine: a W-bit serializer with SCLK_DIV timing.
  - Handshake: start/word in, done out; drives sh_cp/st_cp/ds.
  - The scanner and buffers remain in the top.

Test Plan:
- Test parameters: DIGITS=8, CLK_FREQ_HZ=1_000_000, SCAN_HZ=10_000, SCLK_DIV=2; tick every 100 cycles, W=16.
- Reset release, then load 0x01234567, all enabled: first frame decodes digit0 word = {1, 0x78 (~0x07), 0xFE}, i.e. 0xF8FE, MSB first. st_cp rises 65 cycles after the tick. load_ack fires once.
- digit_en=0x7F, dp_mask=0x01, data 0x89ABCDEF: the digit7 word has sel=0xFF and seg off. The digit0 word has dp=0 (on) and seg=~0x71.
- load 0x11111111 then load 0x22222222 mid-frame (digit 3): digits 3-7 still show 1. load_ack fires once at the frame boundary, and the next frame shows 2 on all digits.
- Reset asserted 20 cycles into a shift: sh_cp, st_cp and ds go to 0 asynchronously. After release, shifting restarts at digit 0 on the next tick.
- With HEX_SCAN_LEADING_ZERO_BLANK_EN, data 0x00000340: digits 3-7 are blanked, digits 0-2 show 0, 4, 3. With data 0x00000000, only digit 0 shows 0.
